// File: rtl/amer_pkg.sv
// Shared definitions for the approximate-multiplier accumulator and its bench.
package amer_pkg;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 24;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/amer_acc.sv
// Streaming accumulator that sums a programmed number of unsigned multiplier
// products and presents the wrapped sum with a sticky carry-out flag.
module amer_acc #(
    parameter int PROD_W = amer_pkg::PROD_W,
    parameter int ACC_W  = amer_pkg::ACC_W,
    parameter int LEN_W  = amer_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);
    import amer_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [LEN_W-1:0]   rem;
    logic [ACC_W:0]     sum_ext;

    // One extra bit on the adder captures the carry that feeds the sticky flag.
    assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_z};
    assign in_ready = (state == ACCUM);
    assign out_sum  = acc;
    assign out_ovf  = ovf;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid && (rem == LEN_W'(1))) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            rem       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == HOLD);
            busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        ovf <= 1'b0;
                        rem <= len;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= sum_ext[ACC_W-1:0];
                        ovf <= ovf | sum_ext[ACC_W];
                        rem <= rem - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/amer_acc.md
# amer_acc

Streaming accumulator directly downstream of the combinational 8x8 approximate multiplier. It consumes its 16-bit product Z, one per valid/ready handshake, and sums a programmed number of products into a wide register. It then presents the sum with a sticky overflow flag on a valid/ready output port. The block turns the multiplier into an approximate dot-product/MAC engine for the error-characterisation benches.

## Interface
- PROD_W, 16, width of incoming product (multiplier Z width)
- ACC_W, 24, accumulator/sum width; must be >= PROD_W
- LEN_W, 8, width of the product-count field
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- start  in  1  begin a new accumulation; sampled only in IDLE
- len  in  LEN_W  number of products to accumulate, latched on accepted start
- in_valid  in  1  product on in_z valid
- in_ready  out  1  block accepts a product this cycle
- in_z  in  PROD_W  unsigned product from the multiplier
- out_valid  out  1  out_sum/out_ovf valid
- out_ready  in  1  consumer takes the result
- out_sum  out  ACC_W  accumulated sum, modulo 2^ACC_W
- out_ovf  out  1  sticky: a carry out of ACC_W occurred during this accumulation
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCUM, HOLD. Registered state, registered outputs except in_ready.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1, clear acc and ovf, then latch rem=len.
  - If len==0, go to HOLD (result 0, ovf 0); else go to ACCUM.
- ACCUM:
  - in_ready=1 (combinational from state).
  - On in_valid&in_ready: acc <= acc + zero-extended in_z; ovf <= ovf | carry out of bit ACC_W-1; rem <= rem-1.
  - If rem==1 at that handshake, go to HOLD.
  - in_valid low stalls with no change.
- HOLD:
  - out_valid=1; out_sum=acc and out_ovf=ovf held stable.
  - On out_ready=1, go to IDLE. out_sum keeps its last value in IDLE; out_valid drops.
- start outside IDLE is ignored; no queuing.
- in_z is unsigned; no saturation. The sum wraps and ovf records the wrap.
- Reset (asynchronous, any time): state=IDLE, acc=0, rem=0, ovf=0, out_valid=0, in_ready=0, busy=0, out_sum=0, out_ovf=0. Reset mid-ACCUM discards the partial sum with no output.

## Timing
- Accumulation is a single-cycle add; one product per clock at full throughput.
- Start accepted at cycle t:
  - busy=1 and in_ready=1 from t+1.
  - The N-th handshake at cycle u gives out_valid=1 at u+1.
  - Minimum start-to-out_valid latency is N+1 cycles.
- len==0: out_valid=1 at t+1.
- Handshake at u+1 with out_ready=1: IDLE at u+2. A start at u+2 is accepted, giving a minimum 1-cycle gap between jobs.
- in_ready=0 while out_valid=1; there is no overlap of input and output phases.
- The ovf update uses the same add result as acc; a carry on the final product is reflected in out_ovf.

## Structure
- Shared package amer_pkg:
  - state enum {IDLE, ACCUM, HOLD}.
  - Default width constants PROD_W, ACC_W, LEN_W.
  - Used by amer_acc and its bench.
- Single module with no sub-module.
- The FSM, counter and adder are small enough to stay in one always block plus the next-state logic.
- The multiplier is instantiated beside this block by the integrating top, not inside it.

## Test plan
- len=3, products 100, 200, 300 back-to-back, out_ready=1 → out_valid at cycle 4 after start; out_sum=600, out_ovf=0; busy falls the cycle after.
- len=0 → out_valid one cycle after start; out_sum=0, out_ovf=0; in_ready never asserted.
- len=2, in_valid gapped (1, 0, 0, 1), out_ready held low 5 cycles → out_valid stays high with out_sum stable for all 5 cycles; IDLE one cycle after out_ready rises.
- ACC_W=16, len=2, products 0xFFFF then 0x0002 → out_sum=0x0001, out_ovf=1. The next job with len=1 and product 5 gives out_sum=5, out_ovf=0 (sticky flag cleared on start).
- start pulsed during ACCUM and during HOLD → ignored; the in-flight result is unchanged and no extra job runs.
- rst_n pulled low after 2 of 4 products → all outputs zero immediately (asynchronous). A new len=1 job with product 7 then gives out_sum=7.
